lcd_spi_sink: RTL and testbench
===============================

LCD_SPI_SINK -- requirements
Module: lcd_spi_sink

Interface
REQ-001 Parameter WIDTH, default 240, panel columns; pixels with x >= WIDTH are clipped.
REQ-002 Parameter HEIGHT, default 240, panel rows; pixels with y >= HEIGHT are clipped.
REQ-003 clk  in  1  system clock; SHALL run at least 4x the lcd_sclk frequency.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 lcd_cs  in  1  SPI chip select, active-low, asynchronous to clk.
REQ-006 lcd_dc  in  1  data/command select: 0 = command byte, 1 = parameter/data byte.
REQ-007 lcd_sclk  in  1  SPI clock, mode 0, idle low.
REQ-008 lcd_mosi  in  1  SPI serial data, MSB first.
REQ-009 byte_valid  out  1  one-cycle pulse per received byte.
REQ-010 byte_data  out  8  received byte; valid while byte_valid=1.
REQ-011 byte_dc  out  1  dc level captured with the byte.
REQ-012 pix_valid  out  1  one-cycle pixel write strobe.
REQ-013 pix_x  out  9  pixel column.
REQ-014 pix_y  out  9  pixel row.
REQ-015 pix_data  out  16  RGB565 pixel value.
REQ-016 frame_done  out  1  one-cycle pulse, coincident with the last pixel of the window.
REQ-017 cmd_err  out  1  one-cycle pulse on a rejected CASET/RASET.

Function
REQ-018 lcd_cs, lcd_dc, lcd_sclk and lcd_mosi SHALL each pass through a 2-flop synchronizer before use.
REQ-019 A rising lcd_sclk edge detected while synchronized cs=0 SHALL shift synchronized mosi into an 8-bit shift register and increment a 3-bit counter.
REQ-020 On the 8th edge, byte_data/byte_dc SHALL load, and byte_valid SHALL pulse in the next clk cycle; dc is sampled on that 8th edge.
REQ-021 cs high SHALL clear the bit counter and discard any partial byte; decoder state is retained across cs toggles.
REQ-022 Decoder states: CMD, CASET, RASET, RAMWR, SKIP; state updates only on byte_valid.
REQ-023 Any byte with dc=0 SHALL be decoded from any state: 0x2A->CASET, 0x2B->RASET, 0x2C->RAMWR, all others->SKIP; the param index and pixel half-byte flag clear.
REQ-024 CASET/RASET: four dc=1 bytes = start hi, start lo, end hi, end lo (16-bit each); the lower 9 bits are committed after the 4th byte, then the state goes to SKIP.
REQ-025 If start > end, the window SHALL stay unchanged and cmd_err SHALL pulse with the 4th byte's commit.
REQ-026 Entering RAMWR SHALL set the cursor to (xs, ys).
REQ-027 RAMWR: dc=1 bytes pair high-then-low; the 2nd byte raises pix_valid one cycle after its byte_valid, carrying the current cursor.
REQ-028 After each pixel: if x != xe then x+1; else x=xs and, if y != ye, y+1; else cursor=(xs, ys) and frame_done pulses with that pixel.
REQ-029 Clipped pixels (x >= WIDTH or y >= HEIGHT) SHALL suppress pix_valid and frame_done, but the cursor still advances.
REQ-030 A dc=0 byte arriving with an odd pending data byte SHALL drop that byte without a pixel.
REQ-031 SKIP and CMD states SHALL ignore dc=1 bytes.

Reset
REQ-032 While rst_n=0: all outputs 0, synchronizers 0, state CMD, bit counter 0, window xs=0, xe=WIDTH-1, ys=0, ye=HEIGHT-1, cursor (0,0).
REQ-033 Reset mid-byte or mid-pixel SHALL discard all partial data; the first full byte after release decodes normally.

Verification
REQ-034 cs low, send 0xA5 with dc=1 -> one byte_valid, byte_data=0xA5, byte_dc=1, no pix_valid.
REQ-035 CASET 00 0A 00 0B, RASET 00 14 00 15, RAMWR, four pixels 0xF800, 0x07E0, 0x001F, 0xFFFF -> pix (10,20), (11,20), (10,21), (11,21) with those values; frame_done only on the 4th.
REQ-036 CASET 00 05 00 02 -> cmd_err pulse; a following RAMWR of one pixel lands at (0,0).
REQ-037 Window x 238..241, y 0..0, four pixels -> pix_valid only for x=238 and 239; cursor returns to (238,0); no frame_done.
REQ-038 cs raised after 5 bits, then a full 0x2C byte -> only one byte_valid (0x2C), state RAMWR.
REQ-039 RAMWR, one data byte, then command 0x00, then RAMWR and 2 bytes 0x12 0x34 -> one pixel 0x1234 at (xs,ys).

Source files
------------

// File: rtl/lcd_spi_sink.sv
// SPI sink for an LCD command/pixel stream: oversamples a mode-0 SPI bus,
// decodes CASET/RASET/RAMWR and emits pixel writes within the addressed window.
module lcd_spi_sink #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 240
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lcd_cs,
  input  logic        lcd_dc,
  input  logic        lcd_sclk,
  input  logic        lcd_mosi,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        pix_valid,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        frame_done,
  output logic        cmd_err
);

  typedef enum logic [2:0] {ST_CMD, ST_CASET, ST_RASET, ST_RAMWR, ST_SKIP} state_t;

  localparam logic [9:0] X_LIM = 10'(WIDTH);
  localparam logic [9:0] Y_LIM = 10'(HEIGHT);

  logic [1:0] cs_sync, dc_sync, sclk_sync, mosi_sync;
  logic       sclk_prev;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt;

  wire cs_s      = cs_sync[1];
  wire dc_s      = dc_sync[1];
  wire mosi_s    = mosi_sync[1];
  wire sclk_rise = sclk_sync[1] & ~sclk_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two-stage synchronizers into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '0;
      dc_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], lcd_cs};
      dc_sync   <= {dc_sync[0], lcd_dc};
      sclk_sync <= {sclk_sync[0], lcd_sclk};
      mosi_sync <= {mosi_sync[0], lcd_mosi};
      sclk_prev <= sclk_sync[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift_q <= {shift_q[6:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_data  <= {shift_q[6:0], mosi_s};
          byte_dc    <= dc_s;
          byte_valid <= 1'b1;
        end
      end
    end
  end

  state_t      state, state_nx;
  logic [1:0]  param_idx;
  logic [15:0] start_val;
  logic [7:0]  end_hi, hi_byte;
  logic        half;
  logic [8:0]  xs, xe, ys, ye, cur_x, cur_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_CMD;
    else        state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    if (byte_valid && !byte_dc) begin
      case (byte_data)
        8'h2A:   state_nx = ST_CASET;
        8'h2B:   state_nx = ST_RASET;
        8'h2C:   state_nx = ST_RAMWR;
        default: state_nx = ST_SKIP;
      endcase
    end else if (byte_valid && (state == ST_CASET || state == ST_RASET) && param_idx == 2'd3) begin
      state_nx = ST_SKIP;
    end
  end

  logic        is_cmd, is_win, is_pix, commit, win_bad, in_bounds, x_last, y_last;
  logic [15:0] end_val;

  always_comb begin
    is_cmd    = byte_valid & ~byte_dc;
    is_win    = byte_valid & byte_dc & (state == ST_CASET || state == ST_RASET);
    is_pix    = byte_valid & byte_dc & (state == ST_RAMWR) & half;
    commit    = is_win & (param_idx == 2'd3);
    end_val   = {end_hi, byte_data};
    win_bad   = start_val > end_val;
    in_bounds = ({1'b0, cur_x} < X_LIM) && ({1'b0, cur_y} < Y_LIM);
    x_last    = cur_x == xe;
    y_last    = cur_y == ye;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      param_idx  <= '0;
      start_val  <= '0;
      end_hi     <= '0;
      hi_byte    <= '0;
      half       <= 1'b0;
      xs         <= '0;
      xe         <= 9'(WIDTH - 1);
      ys         <= '0;
      ye         <= 9'(HEIGHT - 1);
      cur_x      <= '0;
      cur_y      <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= '0;
      frame_done <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      cmd_err    <= 1'b0;
      if (is_cmd) begin
        param_idx <= '0;
        half      <= 1'b0;
        if (byte_data == 8'h2C) begin
          cur_x <= xs;
          cur_y <= ys;
        end
      end else if (is_win) begin
        param_idx <= param_idx + 2'd1;
        case (param_idx)
          2'd0: start_val[15:8] <= byte_data;
          2'd1: start_val[7:0]  <= byte_data;
          2'd2: end_hi          <= byte_data;
          default: ;
        endcase
        if (commit) begin
          if (win_bad) begin
            cmd_err <= 1'b1;
          end else if (state == ST_CASET) begin
            xs <= start_val[8:0];
            xe <= end_val[8:0];
          end else begin
            ys <= start_val[8:0];
            ye <= end_val[8:0];
          end
        end
      end else if (byte_valid && byte_dc && state == ST_RAMWR) begin
        if (!half) begin
          hi_byte <= byte_data;
          half    <= 1'b1;
        end else begin
          half     <= 1'b0;
          pix_data <= {hi_byte, byte_data};
          pix_x    <= cur_x;
          pix_y    <= cur_y;
          // Clipped pixels still walk the cursor so the window stays aligned.
          pix_valid  <= in_bounds;
          frame_done <= in_bounds & x_last & y_last;
          if (!x_last) begin
            cur_x <= cur_x + 9'd1;
          end else begin
            cur_x <= xs;
            cur_y <= y_last ? ys : cur_y + 9'd1;
          end
        end
      end
    end
  end

  logic unused_pix;
  assign unused_pix = is_pix;

endmodule

// File: tb/tb_lcd_spi_sink.sv
// Self-checking bench for lcd_spi_sink: drives SPI traffic and compares the
// byte/pixel streams against a window-indexed reference model.
module tb_lcd_spi_sink;

  localparam int WIDTH  = 240;
  localparam int HEIGHT = 240;
  localparam int HALF   = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lcd_cs = 1'b1, lcd_dc = 1'b0, lcd_sclk = 1'b0, lcd_mosi = 1'b0;
  logic        byte_valid, byte_dc, pix_valid, frame_done, cmd_err;
  logic [7:0]  byte_data;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] pix_data;

  always #5 clk = ~clk;

  lcd_spi_sink #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_cs(lcd_cs), .lcd_dc(lcd_dc),
    .lcd_sclk(lcd_sclk), .lcd_mosi(lcd_mosi),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_done(frame_done), .cmd_err(cmd_err)
  );

  typedef struct {
    logic [8:0]  x, y;
    logic [15:0] d;
    logic        fd;
    logic        after_bv;
  } pix_t;

  pix_t       obs_pix[$], exp_pix[$];
  logic [8:0] obs_byte[$], exp_byte[$];
  int         obs_err, exp_err, stray_fd;
  int         compared = 0, mismatched = 0;
  logic       prev_bv = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_bv = 1'b0;
    end else begin
      if (byte_valid) obs_byte.push_back({byte_dc, byte_data});
      if (pix_valid) obs_pix.push_back('{pix_x, pix_y, pix_data, frame_done, prev_bv});
      else if (frame_done) stray_fd++;
      if (cmd_err) obs_err++;
      prev_bv = byte_valid;
    end
  end

  // Reference model: pixels are located by their ordinal within the window.
  int         m_cmd, m_xs, m_xe, m_ys, m_ye, m_n, m_have_hi;
  logic [7:0] m_hi;
  logic [7:0] m_par[$];

  task automatic model_reset();
    m_cmd = 0; m_xs = 0; m_xe = WIDTH - 1; m_ys = 0; m_ye = HEIGHT - 1;
    m_n = 0; m_have_hi = 0; m_par.delete();
    obs_pix.delete(); exp_pix.delete(); obs_byte.delete(); exp_byte.delete();
    obs_err = 0; exp_err = 0; stray_fd = 0;
  endtask

  task automatic model_byte(input logic dc, input logic [7:0] b);
    int s, e, w, h, idx, x, y;
    exp_byte.push_back({dc, b});
    if (!dc) begin
      m_have_hi = 0;
      m_par.delete();
      m_cmd = (b == 8'h2A) ? 1 : (b == 8'h2B) ? 2 : (b == 8'h2C) ? 3 : 0;
      if (m_cmd == 3) m_n = 0;
    end else if (m_cmd == 1 || m_cmd == 2) begin
      m_par.push_back(b);
      if (m_par.size() == 4) begin
        s = m_par[0] * 256 + m_par[1];
        e = m_par[2] * 256 + m_par[3];
        if (s > e) exp_err++;
        else if (m_cmd == 1) begin m_xs = s % 512; m_xe = e % 512; end
        else begin m_ys = s % 512; m_ye = e % 512; end
        m_cmd = 0;
      end
    end else if (m_cmd == 3) begin
      if (!m_have_hi) begin
        m_hi = b; m_have_hi = 1;
      end else begin
        m_have_hi = 0;
        w = m_xe - m_xs + 1;
        h = m_ye - m_ys + 1;
        idx = m_n % (w * h);
        x = m_xs + idx % w;
        y = m_ys + idx / w;
        m_n++;
        if (x < WIDTH && y < HEIGHT)
          exp_pix.push_back('{9'(x), 9'(y), {m_hi, b}, idx == w * h - 1, 1'b1});
      end
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      lcd_mosi = b[i];
      #HALF lcd_sclk = 1'b1;
      #HALF lcd_sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    lcd_dc = dc;
    send_bits(b, 8);
    model_byte(dc, b);
  endtask

  task automatic send_pixel(input logic [15:0] d);
    send_byte(1'b1, d[15:8]);
    send_byte(1'b1, d[7:0]);
  endtask

  task automatic send_window(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e);
    send_byte(1'b0, cmd);
    send_byte(1'b1, s[15:8]); send_byte(1'b1, s[7:0]);
    send_byte(1'b1, e[15:8]); send_byte(1'b1, e[7:0]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();
    #1 rst_n = 1'b1;
    lcd_cs = 1'b0;
    #30;
  endtask

  task automatic settle();
    repeat (12) @(posedge clk);
  endtask

  task automatic flush_scoreboard(input string name);
    compared++;
    if (obs_byte.size() != exp_byte.size()) begin
      mismatched++;
      $display("FAIL %s byte_count: got %0d want %0d", name, obs_byte.size(), exp_byte.size());
    end
    for (int i = 0; i < obs_byte.size() && i < exp_byte.size(); i++) begin
      compared++;
      if (obs_byte[i] !== exp_byte[i]) begin
        mismatched++;
        $display("FAIL %s byte[%0d]: got %h want %h", name, i, obs_byte[i], exp_byte[i]);
      end
    end
    compared++;
    if (obs_pix.size() != exp_pix.size()) begin
      mismatched++;
      $display("FAIL %s pix_count: got %0d want %0d", name, obs_pix.size(), exp_pix.size());
    end
    for (int i = 0; i < obs_pix.size() && i < exp_pix.size(); i++) begin
      compared++;
      if (obs_pix[i] !== exp_pix[i]) begin
        mismatched++;
        $display("FAIL %s pix[%0d]: got (%0d,%0d) %h fd=%b bv=%b want (%0d,%0d) %h fd=%b bv=%b",
                 name, i, obs_pix[i].x, obs_pix[i].y, obs_pix[i].d, obs_pix[i].fd, obs_pix[i].after_bv,
                 exp_pix[i].x, exp_pix[i].y, exp_pix[i].d, exp_pix[i].fd, exp_pix[i].after_bv);
      end
    end
    compared += 2;
    if (obs_err != exp_err) begin
      mismatched++;
      $display("FAIL %s cmd_err_count: got %0d want %0d", name, obs_err, exp_err);
    end
    if (stray_fd != 0) begin
      mismatched++;
      $display("FAIL %s stray_frame_done: got %0d want 0", name, stray_fd);
    end
    obs_pix.delete(); exp_pix.delete(); obs_byte.delete(); exp_byte.delete();
    obs_err = 0; exp_err = 0; stray_fd = 0;
  endtask

  task automatic test_reset();
    model_reset();
    lcd_cs = 1'b0;
    lcd_dc = 1'b1;
    send_bits(8'h2C, 8);
    @(negedge clk);
    compared += 2;
    if ({byte_valid, byte_data, byte_dc} !== '0) begin
      mismatched++;
      $display("FAIL reset_byte_out: got %b want 0", {byte_valid, byte_data, byte_dc});
    end
    if ({pix_valid, pix_x, pix_y, pix_data, frame_done, cmd_err} !== '0) begin
      mismatched++;
      $display("FAIL reset_pix_out: got %h want 0", {pix_valid, pix_x, pix_y, pix_data, frame_done, cmd_err});
    end
    lcd_cs = 1'b1;
  endtask

  task automatic test_single_byte();
    do_reset();
    send_byte(1'b1, 8'hA5);
    settle();
    compared++;
    if (obs_byte.size() != 1 || obs_byte[0] !== 9'h1A5 || obs_pix.size() != 0) begin
      mismatched++;
      $display("FAIL single_byte: got %0d bytes %0d pixels want one byte 1a5 no pixels",
               obs_byte.size(), obs_pix.size());
    end
    flush_scoreboard("single_byte");
  endtask

  task automatic test_window();
    logic [8:0]  ex[4] = '{10, 11, 10, 11};
    logic [8:0]  ey[4] = '{20, 20, 21, 21};
    logic [15:0] ed[4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
    do_reset();
    send_window(8'h2A, 16'd10, 16'd11);
    send_window(8'h2B, 16'd20, 16'd21);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 4; i++) send_pixel(ed[i]);
    settle();
    compared++;
    if (obs_pix.size() != 4) begin
      mismatched++;
      $display("FAIL window_count: got %0d want 4", obs_pix.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        compared++;
        if (obs_pix[i].x !== ex[i] || obs_pix[i].y !== ey[i] || obs_pix[i].d !== ed[i] ||
            obs_pix[i].fd !== (i == 3)) begin
          mismatched++;
          $display("FAIL window_pix%0d: got (%0d,%0d) %h fd=%b want (%0d,%0d) %h fd=%b", i,
                   obs_pix[i].x, obs_pix[i].y, obs_pix[i].d, obs_pix[i].fd, ex[i], ey[i], ed[i], i == 3);
        end
      end
    end
    flush_scoreboard("window");
  endtask

  task automatic test_bad_caset();
    do_reset();
    send_window(8'h2A, 16'd5, 16'd2);
    send_byte(1'b0, 8'h2C);
    send_pixel(16'hBEEF);
    settle();
    compared++;
    if (obs_err != 1 || obs_pix.size() != 1 || obs_pix[0].x !== 9'd0 || obs_pix[0].y !== 9'd0) begin
      mismatched++;
      $display("FAIL bad_caset: got err=%0d pixels=%0d want err=1 one pixel at (0,0)", obs_err, obs_pix.size());
    end
    flush_scoreboard("bad_caset");
  endtask

  task automatic test_clip();
    do_reset();
    send_window(8'h2A, 16'd238, 16'd241);
    send_window(8'h2B, 16'd0, 16'd0);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 5; i++) send_pixel(16'(16'h1000 + i));
    settle();
    compared++;
    if (obs_pix.size() != 3 || obs_pix[0].x !== 9'd238 || obs_pix[1].x !== 9'd239 ||
        obs_pix[2].x !== 9'd238 || obs_pix[2].d !== 16'h1004 || stray_fd != 0) begin
      mismatched++;
      $display("FAIL clip: got %0d pixels stray_fd=%0d want x=238,239 then wrap to 238", obs_pix.size(), stray_fd);
    end
    flush_scoreboard("clip");
  endtask

  task automatic test_cs_abort();
    do_reset();
    lcd_dc = 1'b0;
    send_bits(8'hFF, 5);
    lcd_cs = 1'b1;
    #100 lcd_cs = 1'b0;
    #30;
    send_byte(1'b0, 8'h2C);
    settle();
    compared++;
    if (obs_byte.size() != 1 || obs_byte[0] !== 9'h02C) begin
      mismatched++;
      $display("FAIL cs_abort_byte: got %0d bytes want one 02c", obs_byte.size());
    end
    send_pixel(16'hCAFE);
    settle();
    compared++;
    if (obs_pix.size() != 1 || obs_pix[0].d !== 16'hCAFE) begin
      mismatched++;
      $display("FAIL cs_abort_ramwr: got %0d pixels want one cafe", obs_pix.size());
    end
    flush_scoreboard("cs_abort");
  endtask

  task automatic test_drop_odd();
    do_reset();
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h99);
    send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h2C);
    send_pixel(16'h1234);
    settle();
    compared++;
    if (obs_pix.size() != 1 || obs_pix[0].d !== 16'h1234 || obs_pix[0].x !== 9'd0 || obs_pix[0].y !== 9'd0) begin
      mismatched++;
      $display("FAIL drop_odd: got %0d pixels want one 1234 at (0,0)", obs_pix.size());
    end
    flush_scoreboard("drop_odd");
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_window(8'h2A, 16'd3, 16'd4);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h55);
    lcd_dc = 1'b1;
    send_bits(8'hAA, 5);
    do_reset();
    send_byte(1'b0, 8'h2C);
    send_pixel(16'h4321);
    settle();
    compared++;
    if (obs_pix.size() != 1 || obs_pix[0].d !== 16'h4321 || obs_pix[0].x !== 9'd0) begin
      mismatched++;
      $display("FAIL mid_reset: got %0d pixels want one 4321 at x=0", obs_pix.size());
    end
    flush_scoreboard("mid_reset");
  endtask

  task automatic test_random();
    int xs, ys, w, h, npix;
    logic [15:0] s, e;
    for (int it = 0; it < 6; it++) begin
      xs = $urandom_range(0, 250); w = $urandom_range(1, 4);
      ys = $urandom_range(0, 245); h = $urandom_range(1, 3);
      s = 16'(xs); e = 16'(xs + w - 1);
      if ($urandom_range(0, 3) == 0) s[15:8] = 8'h01;
      send_window(8'h2A, s, e);
      send_window(8'h2B, 16'(ys), 16'(ys + h - 1));
      send_byte(1'b0, 8'h2C);
      npix = $urandom_range(1, 14);
      for (int p = 0; p < npix; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          lcd_cs = 1'b1;
          #30 lcd_cs = 1'b0;
          #30;
        end
        send_pixel(16'($urandom));
      end
      if ($urandom_range(0, 2) == 0) begin
        send_byte(1'b1, 8'($urandom));
        send_byte(1'b0, 8'h00);
        send_byte(1'b1, 8'($urandom));
      end
      settle();
      flush_scoreboard("random");
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_window();
    test_bad_caset();
    test_clip();
    test_cs_abort();
    test_drop_odd();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
